serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial add/subtract unit: one shared 1-bit full adder processes one operand bit per cycle, LSB first.
//   Trades latency (WIDTH+1 cycles) for area versus a parallel ripple adder.
//   Sits between a register-file style operand source and a result consumer, using a start/done handshake.
//   Adds subtract mode, carry/borrow chaining across words and signed overflow detection.
// PARAMETERS
//   WIDTH     8   operand/result width in bits, >= 1
//   CNT_W     ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1   bit-counter width; derived, do not override
// PORTS
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous, active-high reset
//   start     in   1       request; sampled only when busy=0
//   a         in   WIDTH   operand A; captured on accepted start
//   b         in   WIDTH   operand B; captured on accepted start
//   cin       in   1       carry-in (add) / borrow-in (sub); captured on accepted start
//   sub       in   1       0: a+b+cin   1: a-b-cin; captured on accepted start
//   busy      out  1       high while the FSM is in RUN
//   done      out  1       one-cycle pulse; result valid
//   sum       out  WIDTH   result, held until the next completion
//   cout      out  1       add: carry-out; sub: 1 = no borrow, 0 = borrow
//   overflow  out  1       signed two's-complement overflow of the result
// BEHAVIOUR
//   - Reset (async, any state, including mid-RUN): state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0.
//     Shift regs, counter and carry cleared. An in-flight operation is discarded; no done.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//     - IDLE: on start=1, load a_sr=a, b_sr=(sub ? ~b : b), res_sr=0, cnt=0, carry=(sub ? ~cin : cin); go RUN.
//     - RUN, each cycle: s,c = FA(a_sr[0], b_sr[0], carry).
//       - Shift a_sr/b_sr right; shift s into res_sr MSB; carry<=c; record previous carry as c_msb_in on last bit.
//       - cnt==WIDTH-1 -> DONE.
//     - DONE (1 cycle): done=1; sum<=res_sr; cout<=carry; overflow<=carry ^ c_msb_in.
//       A start seen in DONE is accepted exactly as in IDLE: next state RUN, operands loaded.
//   - Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH.
//     Back-to-back throughput is one operation per WIDTH+1 cycles.
//   - busy=1 exactly during the WIDTH RUN cycles; start while busy=1 is ignored; inputs are don't-care.
//   - sum/cout/overflow change only on the DONE edge; stable otherwise, including across ignored starts.
//   - WIDTH=1: single RUN cycle; overflow = cout ^ carry-in to that bit.
//   - Arithmetic is modulo 2^WIDTH; no saturation.
// STRUCTURE
//   - Shared package serial_adder_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the CNT_W derivation function.
//   - Sub-module: full_adder (existing 1-bit a,b,cin -> sum,cout) instantiated once as the datapath bit slice.
//   - Top holds the FSM, the counter, three WIDTH-bit shift regs and the carry flop.
// TESTING
//   - WIDTH=8, add 8'h0F+8'h01, cin=0 -> done exactly 9 cycles after start; sum=8'h10, cout=0, overflow=0.
//   - WIDTH=8, add 8'hFF+8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0.
//     8'h7F+8'h01 -> sum=8'h80, cout=0, overflow=1.
//   - WIDTH=8, sub 8'h05-8'h07, cin=0 -> sum=8'hFE, cout=0 (borrow), overflow=0.
//     8'h80-8'h01 -> sum=8'h7F, cout=1, overflow=1.
//   - Start pulsed again mid-RUN with different operands -> ignored; first result unchanged, a single done pulse.
//     Start held high through DONE -> second operation begins, done again 9 cycles later.
//   - rst asserted at RUN cycle 4 -> busy=0, sum=0, no done pulse; a new start afterwards completes correctly.
//   - WIDTH=1, all 8 (a,b,cin) combos with sub=0 -> {cout,sum} equals the full-adder truth table, done 2 cycles after start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial add/subtract unit:
//   - state_t   : FSM state encoding (IDLE, RUN, DONE)
//   - cnt_w_f() : bit-counter width derived from the operand width
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A counter needs at least one bit even when WIDTH=1.
  function automatic int cnt_w_f(input int width);
    return ($clog2(width) > 0) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Single-bit full adder used as the shared datapath slice.
//   Ports:
//     a, b, cin : operand bits and carry-in
//     sum       : a ^ b ^ cin
//     cout      : majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial add/subtract unit. One full adder processes one operand bit
//   per cycle, LSB first. An operation takes WIDTH RUN cycles followed by a
//   single DONE cycle in which done pulses and the result is valid.
//   Ports:
//     clk       rising-edge clock
//     rst       asynchronous active-high reset
//     start     request, accepted in IDLE or DONE
//     a, b      operands (WIDTH bits), captured on accepted start
//     cin       carry-in (add) / borrow-in (sub), captured on accepted start
//     sub       0: a+b+cin, 1: a-b-cin, captured on accepted start
//     busy      high during the WIDTH RUN cycles
//     done      one-cycle pulse, result valid
//     sum       result, held until the next completion
//     cout      add: carry-out; sub: 1 = no borrow, 0 = borrow
//     overflow  signed two's-complement overflow of the result
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_w_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_last;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_res_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;

  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_fa_s;
  logic               w_fa_c;
  logic [WIDTH:0]     w_res_cat;
  logic [WIDTH-1:0]   w_res_nxt;

  full_adder u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .sum  (w_fa_s),
    .cout (w_fa_c)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no
  // special-cased slice.
  assign w_res_cat = {w_fa_s, r_res_sr};
  assign w_res_nxt = w_res_cat[WIDTH:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start here chains straight into the next operation.
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~cin: inverting the borrow-in makes the adder
  // carry-in 1 for a plain a-b, and the final carry reads as "no borrow".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_a_sr   <= a;
      r_b_sr   <= sub ? ~b : b;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_carry  <= sub ? ~cin : cin;
    end else if (r_state == ST_RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res_sr <= w_res_nxt;
      r_carry  <= w_fa_c;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        // Result registers are written on the edge entering DONE so they
        // are already valid while done is high. r_carry is still the
        // carry into the MSB here, so XOR with the carry out of it gives
        // signed overflow.
        r_sum  <= w_res_nxt;
        r_cout <= w_fa_c;
        r_ovf  <= w_fa_c ^ r_carry;
      end
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Bench for serial_adder with a WIDTH=8 and a WIDTH=1 instance sharing
//   clock and reset. An arithmetic model predicts busy/done/result each
//   cycle; directed operations also check hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       chk_en = 1'b0;

  logic       s8_start = 1'b0;
  logic [7:0] s8_a = '0;
  logic [7:0] s8_b = '0;
  logic       s8_cin = 1'b0;
  logic       s8_sub = 1'b0;
  logic       o8_busy, o8_done, o8_cout, o8_ovf;
  logic [7:0] o8_sum;

  logic       s1_start = 1'b0;
  logic [0:0] s1_a = '0;
  logic [0:0] s1_b = '0;
  logic       s1_cin = 1'b0;
  logic       s1_sub = 1'b0;
  logic       o1_busy, o1_done, o1_cout, o1_ovf;
  logic [0:0] o1_sum;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b),
    .cin(s8_cin), .sub(s8_sub), .busy(o8_busy), .done(o8_done),
    .sum(o8_sum), .cout(o8_cout), .overflow(o8_ovf)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b),
    .cin(s1_cin), .sub(s1_sub), .busy(o1_busy), .done(o1_done),
    .sum(o1_sum), .cout(o1_cout), .overflow(o1_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: returns {overflow, cout, sum} for a w-bit op.
  function automatic logic [9:0] model_res(input int w, input int ua, input int ub,
                                           input int ci, input bit is_sub);
    int  r, sa, sbv, sr, half, full;
    logic       co, ov;
    logic [7:0] s;
    full = 1 << w;
    half = full / 2;
    if (is_sub) begin
      r  = ua - ub - ci;
      co = (r >= 0);
    end else begin
      r  = ua + ub + ci;
      co = (r >= full);
    end
    s   = 8'(r & (full - 1));
    sa  = (ua >= half) ? ua - full : ua;
    sbv = (ub >= half) ? ub - full : ub;
    sr  = is_sub ? (sa - sbv - ci) : (sa + sbv + ci);
    ov  = (sr >= half) || (sr < -half);
    return {ov, co, s};
  endfunction

  // Cycle-level model: an accepted start schedules done WIDTH edges later.
  int         m8_left = 0, m1_left = 0;
  logic       m8_done = 1'b0, m1_done = 1'b0;
  logic [9:0] pend8 = '0, exp8 = '0, pend1 = '0, exp1 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_left <= 0; m8_done <= 1'b0; exp8 <= '0;
      m1_left <= 0; m1_done <= 1'b0; exp1 <= '0;
    end else begin
      if (m8_left > 0) begin
        m8_left <= m8_left - 1;
        m8_done <= (m8_left == 1);
        if (m8_left == 1) exp8 <= pend8;
      end else begin
        m8_done <= 1'b0;
        if (s8_start) begin
          m8_left <= 8;
          pend8   <= model_res(8, int'(s8_a), int'(s8_b), int'(s8_cin), s8_sub);
        end
      end
      if (m1_left > 0) begin
        m1_left <= m1_left - 1;
        m1_done <= (m1_left == 1);
        if (m1_left == 1) exp1 <= pend1;
      end else begin
        m1_done <= 1'b0;
        if (s1_start) begin
          m1_left <= 1;
          pend1   <= model_res(1, int'(s1_a), int'(s1_b), int'(s1_cin), s1_sub);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m8_busy", 32'(o8_busy), 32'(m8_left > 0));
      chk("m8_done", 32'(o8_done), 32'(m8_done));
      chk("m8_sum",  32'(o8_sum),  32'(exp8[7:0]));
      chk("m8_cout", 32'(o8_cout), 32'(exp8[8]));
      chk("m8_ovf",  32'(o8_ovf),  32'(exp8[9]));
      chk("m1_busy", 32'(o1_busy), 32'(m1_left > 0));
      chk("m1_done", 32'(o1_done), 32'(m1_done));
      chk("m1_sum",  32'(o1_sum),  32'(exp1[0]));
      chk("m1_cout", 32'(o1_cout), 32'(exp1[8]));
      chk("m1_ovf",  32'(o1_ovf),  32'(exp1[9]));
    end
  end

  // Start one WIDTH=8 op and check the literal result and latency
  // (start cycle = 0, done expected in cycle 9).
  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb, input logic [7:0] es,
                     input logic ec, input logic eo);
    int cyc;
    bit seen;
    @(negedge clk);
    s8_start = 1'b1; s8_a = a; s8_b = b; s8_cin = ci; s8_sub = sb;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      s8_start = 1'b0;
      if (o8_done) seen = 1'b1;
    end
    chk({nm, "_lat"},  32'(cyc), 32'd9);
    chk({nm, "_sum"},  32'(o8_sum), 32'(es));
    chk({nm, "_cout"}, 32'(o8_cout), 32'(ec));
    chk({nm, "_ovf"},  32'(o8_ovf), 32'(eo));
  endtask

  logic [1:0] ft [0:7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  initial begin
    int cyc, ndone, c1;
    logic [2:0] idx;

    #2 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(o8_busy), 32'd0);
    chk("rst_done", 32'(o8_done), 32'd0);
    chk("rst_sum",  32'(o8_sum),  32'd0);
    chk("rst_cout", 32'(o8_cout), 32'd0);
    chk("rst_ovf",  32'(o8_ovf),  32'd0);
    rst = 1'b0;

    op8("add0F01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add7F01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("sub0507", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("addcin",  8'h3C, 8'h42, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0);
    op8("subbin",  8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

    // Start pulsed mid-RUN with other operands must be ignored.
    @(negedge clk);
    s8_start = 1'b1; s8_a = 8'h12; s8_b = 8'h34; s8_cin = 1'b0; s8_sub = 1'b0;
    ndone = 0; c1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      s8_start = (k == 4);
      if (k == 4) begin s8_a = 8'hAA; s8_b = 8'h55; s8_sub = 1'b1; end
      if (o8_done) begin ndone++; if (c1 == 0) c1 = k; end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_lat",   32'(c1), 32'd9);
    chk("ign_sum",   32'(o8_sum), 32'h46);
    s8_sub = 1'b0;

    // Start held through DONE chains a second op right away.
    @(negedge clk);
    s8_start = 1'b1; s8_a = 8'h10; s8_b = 8'h20;
    c1 = 0; cyc = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (c1 != 0 && k == c1 + 1) s8_start = 1'b0;
      if (o8_done) begin
        if (c1 == 0) begin
          c1 = k;
          chk("held_sum1", 32'(o8_sum), 32'h30);
          s8_a = 8'h40; s8_b = 8'h05;
        end else if (cyc == 0) begin
          cyc = k;
          chk("held_sum2", 32'(o8_sum), 32'h45);
        end
      end
    end
    chk("held_lat1", 32'(c1), 32'd9);
    chk("held_lat2", 32'(cyc - c1), 32'd9);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    s8_start = 1'b1; s8_a = 8'h33; s8_b = 8'h11;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      s8_start = 1'b0;
    end
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 32'(o8_busy), 32'd0);
    chk("mrst_sum",  32'(o8_sum),  32'd0);
    chk("mrst_done", 32'(o8_done), 32'd0);
    #2 rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o8_done) ndone++;
    end
    chk("mrst_nodone", 32'(ndone), 32'd0);
    op8("post_rst", 8'h21, 8'h13, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0);

    // WIDTH=1: full-adder truth table, done in cycle 2.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      @(negedge clk);
      s1_start = 1'b1; s1_a = idx[2]; s1_b = idx[1]; s1_cin = idx[0]; s1_sub = 1'b0;
      cyc = 0;
      while (!o1_done && cyc < 10) begin
        @(negedge clk);
        cyc++;
        s1_start = 1'b0;
      end
      chk("w1_lat",  32'(cyc), 32'd2);
      chk("w1_fa",   32'({o1_cout, o1_sum}), 32'(ft[i]));
      chk("w1_ovf",  32'(o1_ovf), 32'(ft[i][1] ^ idx[0]));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
